// File: rtl/stats_pkg.sv
// stats_pkg: shared stat indices, command opcodes, scheduler state type and round-robin helper
package stats_pkg;

    localparam int NUM_STATS_C = 6;
    localparam int STAT_IDX_W  = 3;

    localparam logic [STAT_IDX_W-1:0] HUNGER    = 3'd0;
    localparam logic [STAT_IDX_W-1:0] HAPPINESS = 3'd1;
    localparam logic [STAT_IDX_W-1:0] HEALTH    = 3'd2;
    localparam logic [STAT_IDX_W-1:0] HYGIENE   = 3'd3;
    localparam logic [STAT_IDX_W-1:0] ENERGY    = 3'd4;
    localparam logic [STAT_IDX_W-1:0] SOCIAL    = 3'd5;

    localparam logic OP_INC = 1'b0;
    localparam logic OP_DEC = 1'b1;

    typedef enum logic {IDLE, ISSUE} state_t;

    // First set bit of req at or after ptr, wrapping modulo n; ptr is returned when none is set.
    function automatic logic [STAT_IDX_W-1:0] rr_pick(
        input logic [7:0]            req,
        input logic [STAT_IDX_W-1:0] ptr,
        input logic [3:0]            n
    );
        logic [3:0]            s;
        logic [STAT_IDX_W-1:0] r;
        logic                  found;
        r     = ptr;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            s = {1'b0, ptr} + 4'(k);
            if (s >= n) s = s - n;
            if (4'(k) < n && !found && req[s[2:0]]) begin
                r     = s[2:0];
                found = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// lfsr8: free-running 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] o_state
);

    logic [7:0] r_state;

    // Shift left every cycle, feeding back the tap XOR into bit 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= SEED;
        else       r_state <= {r_state[6:0], r_state[7] ^ r_state[5] ^ r_state[4] ^ r_state[3]};
    end

    assign o_state = r_state;

endmodule

// File: rtl/stat_update_scheduler.sv
// stat_update_scheduler: serializes random aging increments and care decrements onto one valid/ready stream
module stat_update_scheduler
    import stats_pkg::*;
#(
    parameter int         TICK_DIV  = 10_000_000,
    parameter int         NUM_STATS = 6,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick_en,
    input  logic [NUM_STATS-1:0] action_req,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [2:0]           cmd_idx,
    output logic                 cmd_op,
    output logic [NUM_STATS-1:0] pending,
    output logic                 aging_overrun
);

    localparam int             TW    = $clog2(TICK_DIV);
    localparam logic [TW-1:0]  TLAST = TW'(TICK_DIV - 1);
    localparam logic [2:0]     NLAST = 3'(NUM_STATS - 1);
    localparam logic [3:0]     NS4   = 4'(NUM_STATS);

    state_t               r_state, w_state_nxt;
    logic [TW-1:0]        r_timer;
    logic                 r_aging_pending;
    logic [2:0]           r_aging_idx;
    logic [2:0]           r_rr_ptr;
    logic [NUM_STATS-1:0] r_pending;
    logic                 r_cmd_valid;
    logic [2:0]           r_cmd_idx;
    logic                 r_cmd_op;
    logic                 r_overrun;

    logic [7:0]           w_lfsr;
    logic                 w_tick;
    logic                 w_hs;
    logic                 w_aging_clr;
    logic                 w_load_aging;
    logic                 w_load_care;
    logic [2:0]           w_rand_idx;
    logic [2:0]           w_care_idx;
    logic [NUM_STATS-1:0] w_care_clr;
    logic                 w_unused;

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .o_state (w_lfsr)
    );

    assign w_unused    = ^w_lfsr[7:3];
    assign w_tick      = tick_en && (r_timer == TLAST);
    assign w_rand_idx  = (w_lfsr[2:0] >= 3'(NUM_STATS)) ? w_lfsr[2:0] - 3'(NUM_STATS) : w_lfsr[2:0];
    assign w_care_idx  = rr_pick(8'(r_pending), r_rr_ptr, NS4);
    assign w_hs        = (r_state == ISSUE) && cmd_ready;
    assign w_aging_clr = w_hs && (r_cmd_op == OP_INC);
    assign w_care_clr  = (w_hs && r_cmd_op == OP_DEC) ? {{(NUM_STATS-1){1'b0}}, 1'b1} << r_cmd_idx : '0;

    // Next state: IDLE launches aging first, then care; ISSUE waits for the handshake.
    always_comb begin
        w_state_nxt  = r_state;
        w_load_aging = 1'b0;
        w_load_care  = 1'b0;
        if (r_state == IDLE) begin
            w_load_aging = r_aging_pending;
            w_load_care  = !r_aging_pending && |r_pending;
            w_state_nxt  = (w_load_aging || w_load_care) ? ISSUE : IDLE;
        end else if (w_hs) begin
            w_state_nxt = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Command register: loaded on launch, held through ISSUE, valid dropped on handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmd_valid <= 1'b0;
            r_cmd_idx   <= 3'd0;
            r_cmd_op    <= OP_INC;
        end else if (w_load_aging) begin
            r_cmd_valid <= 1'b1;
            r_cmd_idx   <= r_aging_idx;
            r_cmd_op    <= OP_INC;
        end else if (w_load_care) begin
            r_cmd_valid <= 1'b1;
            r_cmd_idx   <= w_care_idx;
            r_cmd_op    <= OP_DEC;
        end else if (w_hs) begin
            r_cmd_valid <= 1'b0;
        end
    end

    // Aging timer and single-entry aging queue; a tick that finds the slot still occupied is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer         <= '0;
            r_aging_pending <= 1'b0;
            r_aging_idx     <= 3'd0;
            r_overrun       <= 1'b0;
        end else begin
            if (tick_en) r_timer <= w_tick ? '0 : r_timer + 1'b1;
            if (w_tick && (!r_aging_pending || w_aging_clr)) begin
                r_aging_pending <= 1'b1;
                r_aging_idx     <= w_rand_idx;
            end else if (w_aging_clr) begin
                r_aging_pending <= 1'b0;
            end
            if (w_tick && r_aging_pending && !w_aging_clr) r_overrun <= 1'b1;
        end
    end

    // Care requests latch until issued; a new pulse overrides a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_rr_ptr  <= 3'd0;
        end else begin
            r_pending <= (r_pending & ~w_care_clr) | action_req;
            if (w_hs && r_cmd_op == OP_DEC) r_rr_ptr <= (r_cmd_idx == NLAST) ? 3'd0 : r_cmd_idx + 3'd1;
        end
    end

    assign cmd_valid     = r_cmd_valid;
    assign cmd_idx       = r_cmd_idx;
    assign cmd_op        = r_cmd_op;
    assign pending       = r_pending;
    assign aging_overrun = r_overrun;

endmodule

// File: tb/tb_stat_update_scheduler.sv
// tb_stat_update_scheduler: scenario tasks plus randomized traffic against a behavioural model
module tb_stat_update_scheduler;

    localparam int TD = 8;
    localparam int N  = 6;

    logic         clk = 1'b0;
    logic         reset;
    logic         tick_en;
    logic [N-1:0] action_req;
    logic         cmd_ready;
    logic         cmd_valid;
    logic [2:0]   cmd_idx;
    logic         cmd_op;
    logic [N-1:0] pending;
    logic         aging_overrun;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: what the scheduler should present after each edge.
    int           m_lfsr, m_timer, m_aidx, m_rr, m_idx;
    bit           m_ap, m_valid, m_op, m_ovr;
    logic [N-1:0] m_pend;

    always #5 clk = ~clk;

    stat_update_scheduler #(.TICK_DIV(TD), .NUM_STATS(N), .LFSR_SEED(8'hA5)) dut (
        .clk           (clk),
        .reset         (reset),
        .tick_en       (tick_en),
        .action_req    (action_req),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_idx       (cmd_idx),
        .cmd_op        (cmd_op),
        .pending       (pending),
        .aging_overrun (aging_overrun)
    );

    task automatic model_reset();
        m_lfsr  = 8'hA5;
        m_timer = 0;
        m_aidx  = 0;
        m_rr    = 0;
        m_idx   = 0;
        m_ap    = 0;
        m_valid = 0;
        m_op    = 0;
        m_ovr   = 0;
        m_pend  = '0;
    endtask

    task automatic model_step();
        bit hs, tick, clr, nv, no, found;
        int ni;
        hs   = m_valid && cmd_ready;
        tick = tick_en && (m_timer == TD - 1);
        clr  = hs && !m_op;
        nv = m_valid; ni = m_idx; no = m_op;
        if (!m_valid) begin
            if (m_ap) begin
                nv = 1; ni = m_aidx; no = 0;
            end else if (m_pend != 0) begin
                found = 0;
                for (int k = 0; k < N; k++)
                    if (!found && m_pend[(m_rr + k) % N]) begin
                        found = 1; nv = 1; ni = (m_rr + k) % N; no = 1;
                    end
            end
        end else if (hs) begin
            nv = 0;
        end
        if (hs && m_op) begin
            m_pend = m_pend & ~(N'(1) << m_idx);
            m_rr   = (m_idx + 1) % N;
        end
        m_pend = m_pend | action_req;
        if (tick) begin
            if (m_ap && !clr) m_ovr = 1;
            else begin
                m_ap   = 1;
                m_aidx = (m_lfsr & 7) % N;
            end
        end else if (clr) begin
            m_ap = 0;
        end
        if (tick_en) m_timer = (m_timer + 1) % TD;
        m_lfsr  = ((m_lfsr << 1) & 255) | (((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1);
        m_valid = nv; m_idx = ni; m_op = no;
    endtask

    function automatic logic [11:0] exp_vec();
        return {m_valid, 3'(m_idx), m_op, m_pend, m_ovr};
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        tick_en    = 1'b0;
        action_req = '0;
        cmd_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({cmd_valid, cmd_idx, cmd_op, pending, aging_overrun} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected %h", {cmd_valid, cmd_idx, cmd_op, pending, aging_overrun}, 12'h000);
        end
    endtask

    task automatic test_single_care();
        do_reset();
        cmd_ready  = 1'b1;
        action_req = 6'b001000;
        cyc();
        action_req = '0;
        n_tests++;
        if ({cmd_valid, pending} !== {1'b0, 6'b001000}) begin
            n_fail++;
            $display("FAIL single_latch: got valid=%b pending=%b expected valid=0 pending=001000", cmd_valid, pending);
        end
        cyc();
        n_tests++;
        if ({cmd_valid, cmd_idx, cmd_op} !== {1'b1, 3'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL single_issue: got valid=%b idx=%0d op=%b expected 1/3/1", cmd_valid, cmd_idx, cmd_op);
        end
        cyc();
        n_tests++;
        if ({cmd_valid, pending} !== 7'b0) begin
            n_fail++;
            $display("FAIL single_clear: got valid=%b pending=%b expected 0/000000", cmd_valid, pending);
        end
    endtask

    task automatic test_all_care();
        int  idxs[$];
        int  when[$];
        bit  prev;
        do_reset();
        cmd_ready  = 1'b1;
        action_req = '1;
        cyc();
        action_req = '0;
        prev = 0;
        for (int c = 1; c <= 13; c++) begin
            cyc();
            n_tests++;
            if ({cmd_valid, cmd_idx, cmd_op, pending, aging_overrun} !== exp_vec()) begin
                n_fail++;
                $display("FAIL all_care_cycle%0d: got %h expected %h", c, {cmd_valid, cmd_idx, cmd_op, pending, aging_overrun}, exp_vec());
            end
            if (cmd_valid && !prev) begin
                idxs.push_back(cmd_op ? int'(cmd_idx) : -1);
                when.push_back(c);
            end
            prev = cmd_valid;
        end
        n_tests++;
        if (idxs.size() != 6) begin
            n_fail++;
            $display("FAIL all_care_count: got %0d commands expected 6", idxs.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_tests++;
                if (idxs[i] != i || (i > 0 && when[i] - when[i-1] != 2)) begin
                    n_fail++;
                    $display("FAIL all_care_order%0d: got idx=%0d gap=%0d expected idx=%0d gap=2", i, idxs[i], (i > 0) ? when[i] - when[i-1] : 2, i);
                end
            end
        end
        n_tests++;
        if (pending !== '0) begin
            n_fail++;
            $display("FAIL all_care_drain: got pending=%b expected 000000", pending);
        end
    endtask

    task automatic test_aging_overrun();
        int first;
        first = -1;
        do_reset();
        tick_en = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            cyc();
            n_tests++;
            if ({cmd_valid, cmd_idx, cmd_op, pending, aging_overrun} !== exp_vec()) begin
                n_fail++;
                $display("FAIL aging_cycle%0d: got %h expected %h", c, {cmd_valid, cmd_idx, cmd_op, pending, aging_overrun}, exp_vec());
            end
            if (cmd_valid && first < 0) first = c;
        end
        n_tests++;
        if (first != 9 || cmd_op !== 1'b0 || aging_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL aging_overrun: got first_valid=%0d op=%b overrun=%b expected 9/0/1", first, cmd_op, aging_overrun);
        end
        tick_en   = 1'b0;
        cmd_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cyc();
            n_tests++;
            if ({cmd_valid, cmd_idx, cmd_op, pending, aging_overrun} !== exp_vec()) begin
                n_fail++;
                $display("FAIL aging_drain%0d: got %h expected %h", c, {cmd_valid, cmd_idx, cmd_op, pending, aging_overrun}, exp_vec());
            end
        end
    endtask

    task automatic test_priority();
        int ops[$];
        int idxs[$];
        bit prev;
        do_reset();
        tick_en   = 1'b1;
        cmd_ready = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            action_req = (c == 8) ? 6'b010000 : 6'b0;
            cyc();
        end
        action_req = '0;
        tick_en    = 1'b0;
        prev       = 0;
        for (int c = 0; c < 6; c++) begin
            cyc();
            n_tests++;
            if ({cmd_valid, cmd_idx, cmd_op, pending, aging_overrun} !== exp_vec()) begin
                n_fail++;
                $display("FAIL priority_cycle%0d: got %h expected %h", c, {cmd_valid, cmd_idx, cmd_op, pending, aging_overrun}, exp_vec());
            end
            if (cmd_valid && !prev) begin
                ops.push_back(int'(cmd_op));
                idxs.push_back(int'(cmd_idx));
            end
            prev = cmd_valid;
        end
        n_tests++;
        if (ops.size() != 2 || ops[0] != 0 || ops[1] != 1 || idxs[1] != 4) begin
            n_fail++;
            $display("FAIL priority_order: got %0d commands first_op=%0d second_op=%0d second_idx=%0d expected 2/0/1/4",
                     ops.size(), (ops.size() > 0) ? ops[0] : -1, (ops.size() > 1) ? ops[1] : -1, (idxs.size() > 1) ? idxs[1] : -1);
        end
    endtask

    task automatic test_coalesce();
        do_reset();
        action_req = 6'b000100;
        cyc();
        action_req = '0;
        cyc();
        for (int c = 0; c < 5; c++) begin
            action_req = (c == 2) ? 6'b000100 : 6'b0;
            cyc();
            n_tests++;
            if ({cmd_valid, cmd_idx, cmd_op, pending} !== {1'b1, 3'd2, 1'b1, 6'b000100}) begin
                n_fail++;
                $display("FAIL coalesce_hold%0d: got valid=%b idx=%0d op=%b pending=%b expected 1/2/1/000100", c, cmd_valid, cmd_idx, cmd_op, pending);
            end
        end
        action_req = '0;
        cmd_ready  = 1'b1;
        cyc();
        n_tests++;
        if ({cmd_valid, pending} !== 7'b0) begin
            n_fail++;
            $display("FAIL coalesce_clear: got valid=%b pending=%b expected 0/000000", cmd_valid, pending);
        end
        cyc();
        cyc();
        n_tests++;
        if (cmd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL coalesce_single: got valid=%b expected 0", cmd_valid);
        end
    endtask

    task automatic test_reset_mid_issue();
        do_reset();
        action_req = 6'b100001;
        cyc();
        action_req = '0;
        cyc();
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if ({cmd_valid, cmd_idx, cmd_op, pending} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_mid_issue: got valid=%b idx=%0d op=%b pending=%b expected all zero", cmd_valid, cmd_idx, cmd_op, pending);
        end
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            action_req = ($urandom_range(0, 5) == 0) ? (6'($urandom) & 6'($urandom)) : 6'b0;
            cmd_ready  = ($urandom_range(0, 3) != 0);
            tick_en    = ($urandom_range(0, 9) != 0);
            cyc();
            n_tests++;
            if ({cmd_valid, cmd_idx, cmd_op, pending, aging_overrun} !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %h expected %h", c, {cmd_valid, cmd_idx, cmd_op, pending, aging_overrun}, exp_vec());
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        tick_en    = 1'b0;
        action_req = '0;
        cmd_ready  = 1'b0;
        model_reset();
        test_reset();
        test_single_care();
        test_all_care();
        test_aging_overrun();
        test_priority();
        test_coalesce();
        test_reset_mid_issue();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
